rr_burst_arbiter: RTL

Round-robin arbiter that shares one resource between `N` requesters. Grants are one-hot and registered, and there is no dead cycle when ownership passes from one requester to the next. Each grant is capped at `MAX_HOLD` cycles whenever another requester is waiting. The block sits in front of any shared datapath or bus, and the requesters use it as their request/grant front end.

---
 rtl/arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 44 ++++
 rtl/rr_burst_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and constants for the round-robin burst arbiter.
//   state_t      : arbiter state (IDLE = no owner, GRANT = owner register valid)
//   clog2_min1   : index width helper that never returns zero bits
//   ARB_N        : default requester count
//   ARB_MAX_HOLD : default grant cap under contention
// -----------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int ARB_N        = 4;
  localparam int ARB_MAX_HOLD = 8;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority encoder. Scans req starting at index `start`,
// wrapping modulo N, skipping any bit set in `excl`, and reports the first
// set request found.
// Ports:
//   req   [N-1:0]  : request vector
//   start [IW-1:0] : first index examined
//   excl  [N-1:0]  : mask of requesters that may not be picked
//   found          : a candidate exists
//   idx   [IW-1:0] : index of the chosen requester (0 when none found)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  excl,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [N-1:0] masked;

  assign masked = req & ~excl;

  // Scan from the far end back toward `start` so the candidate nearest
  // `start` is written last and wins; avoids a loop break.
  always_comb begin
    logic [IW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = IW'((int'(start) + i) % N);
      if (masked[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// rr_burst_arbiter
// Round-robin arbiter for N requesters with registered one-hot grants, no dead
// cycle on handover, and a cap of MAX_HOLD consecutive grant cycles whenever
// another requester is waiting. A lone requester is never preempted.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   req       [N-1:0]         : level requests
//   gnt       [N-1:0]         : registered one-hot grant, zero when idle
//   gnt_valid                 : registered OR of gnt
//   gnt_id    [$clog2(N)-1:0] : index of current owner, held while idle
// -----------------------------------------------------------------------------
module rr_burst_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int IW = clog2_min1(N);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] own_q, own_d;
  logic [IW-1:0] last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [N-1:0]  gnt_d;
  logic          gnt_valid_d;

  logic          idle_found, hand_found;
  logic [IW-1:0] idle_idx, hand_idx;
  logic [IW-1:0] idle_start, hand_start;
  logic [N-1:0]  own_mask;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IDX_LAST) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign idle_start = next_idx(last_q);
  assign hand_start = next_idx(own_q);
  assign own_mask   = onehot(own_q);

  // Idle pick: fresh arbitration starting just after the last owner.
  rr_pick #(.N(N), .IW(IW)) u_pick_idle (
    .req   (req),
    .start (idle_start),
    .excl  ('0),
    .found (idle_found),
    .idx   (idle_idx)
  );

  // Handover pick: next waiting requester after the owner, owner excluded.
  rr_pick #(.N(N), .IW(IW)) u_pick_hand (
    .req   (req),
    .start (hand_start),
    .excl  (own_mask),
    .found (hand_found),
    .idx   (hand_idx)
  );

  // ---- state register ------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      own_q     <= '0;
      last_q    <= IDX_LAST;
      hold_q    <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      gnt       <= gnt_d;
      gnt_valid <= gnt_valid_d;
    end
  end

  // own_q doubles as the owner index output; it is left untouched in IDLE.
  assign gnt_id = own_q;

  // ---- next-state logic ----------------------------------------------------
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (idle_found) begin
          state_d = GRANT;
          own_d   = idle_idx;
          last_d  = idle_idx;
          hold_d  = HW'(1);
        end
      end
      GRANT: begin
        // Release takes priority over expiry so a dropping owner never
        // gets re-granted.
        if (!req[own_q]) begin
          if (hand_found) begin
            own_d  = hand_idx;
            last_d = hand_idx;
            hold_d = HW'(1);
          end else begin
            state_d = IDLE;
            hold_d  = '0;
          end
        end else if (hold_q == HOLD_MAX && hand_found) begin
          own_d  = hand_idx;
          last_d = hand_idx;
          hold_d = HW'(1);
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- output logic (registered next cycle) --------------------------------
  always_comb begin
    gnt_d       = '0;
    gnt_valid_d = 1'b0;
    if (state_d == GRANT) begin
      gnt_d       = onehot(own_d);
      gnt_valid_d = 1'b1;
    end
  end

endmodule
